fpu_sequencer: RTL and testbench
================================

# fpu_sequencer

Single-transaction sequencer between the CPU execute stage and `fpu_controller`. It accepts a one-cycle `start` with opcode and operands, runs the stb/ack handshake on the controller's inputs and output, and enforces a timeout. It returns a registered result with a one-cycle `done` pulse. Compare ops (`feq`/`flt`/`fle`, opcodes 1000–1010) have no controller path, so the sequencer evaluates them locally without touching the controller.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in SEND+WAIT before the transaction aborts; legal range 1..65535.

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request strobe; accepted only when `ready`=1
- `op`  in  4  opcode, using the controller encoding (0000–1010)
- `rs1`, `rs2`  in  32  operands
- `ready`  out  1  sequencer is idle and can accept `start`
- `done`  out  1  one-cycle pulse; `result`/`error` are valid
- `result`  out  32  registered result, held until the next `done`
- `error`  out  1  set with `done` on timeout or illegal op
- `fpu_op`  out  4  opcode to the controller, held for the whole transaction
- `fpu_in1`, `fpu_in2`  out  32  latched operands
- `fpu_in1_stb`, `fpu_in2_stb`  out  1  operand strobes
- `fpu_in1_ack`, `fpu_in2_ack`  in  1  operand acks
- `fpu_out`  in  32  controller result
- `fpu_out_stb`  in  1  result strobe
- `fpu_out_ack`  out  1  result ack

## Operation
States: IDLE, SEND, WAIT, ACK, RESP.
- **IDLE**
  - `ready`=1.
  - On `start`: latch `op`/`rs1`/`rs2`.
  - Opcodes 1000–1010: compute the compare result into `result`, `error`=0, go to RESP.
  - Opcodes 1011–1111: `result`=0, `error`=1, go to RESP.
  - Otherwise: clear the timeout counter, go to SEND.
- **SEND**
  - Both stbs assert together.
  - Each ack is captured in its own sticky flag; a stb deasserts in the cycle after its own ack is sampled high.
  - When both flags are set, go to WAIT.
- **WAIT**
  - `fpu_out_ack`=0.
  - When `fpu_out_stb`=1, capture `fpu_out` into `result` and go to ACK.
- **ACK**
  - `fpu_out_ack`=1 for exactly one cycle, then go to RESP.
- **RESP**
  - `done`=1 for one cycle, then go to IDLE.
- **Timeout**
  - The counter increments every cycle in SEND and WAIT.
  - On reaching `TIMEOUT_CYCLES`: drop all stbs, `result`=0, `error`=1, go to RESP.
  - After a timeout the controller state is undefined; only `rst` recovers it.
- **Compare rules** (result = {31'b0, bit})
  - Any NaN operand (exp=0xFF, mant≠0) gives 0 for all three ops.
  - +0 and −0 compare equal.
  - Otherwise ordering is a sign-magnitude compare.
  - Exception flags are out of scope.
- **Held signals**
  - `fpu_op`/`fpu_in1`/`fpu_in2` always come from the latch registers, so they stay stable from SEND through ACK.
- **Ignored inputs**
  - `start` while `ready`=0 is ignored, with no queueing.
- **Reset values**
  - State = IDLE.
  - `ready`=1.
  - `done`=0, `error`=0, `result`=0.
  - `fpu_op`=0, `fpu_in1`=0, `fpu_in2`=0.
  - Both stbs = 0, `fpu_out_ack`=0.
  - Reset mid-transaction forces these values immediately; the controller is reset by the same source.

## Timing
- `start` sampled in cycle 0.
- Local or illegal op: `done` in cycle 1, `ready`=1 again in cycle 2.
- Controller op with zero-wait partner (`fsgnj`):
  - SEND in cycle 1.
  - WAIT captures `fpu_out` in cycle 2.
  - ACK in cycle 3.
  - `done` in cycle 4.
- Minimum controller-op latency is 4 cycles; otherwise the latency is 4 plus the partner's stall cycles.
- `ready` is low from cycle 1 until the cycle after `done`. The next `start` can be accepted in the cycle immediately after `done`.
- `fpu_out_ack` is registered and never asserts in the same cycle that `fpu_out_stb` is first seen.

## Structure
- Shared package `fpu_pkg`:
  - opcode localparams (`FPU_FADD`…`FPU_FLE`)
  - `fpu_seq_state_t` enum
  - `FPU_CANON_ZERO` constant
- Sub-module `fp_compare`: purely combinational; inputs `a`, `b`, `op[1:0]`; output `lt_eq_bit`. Used in IDLE.
- Expected size: about 200 lines of RTL plus about 50 for `fp_compare`.

## Test plan
- **fsgnj**
  - Stimulus: `rs1`=0x3F800000, `rs2`=0x80000000; stub acks and `out_stb` tied to 1.
  - Required: `result`=0xBF800000; `done` in cycle 4; `fpu_out_ack` high for exactly 1 cycle; `error`=0.
- **fadd, skewed acks**
  - Stimulus: stub gives `in1_ack` after 2 cycles, `in2_ack` after 5, and `out_stb`=0x40400000 10 cycles later.
  - Required: each stb drops individually after its own ack; `result`=0x40400000; `fpu_op` stays 0000 throughout.
- **Compares**
  - flt(0xBF800000, 0x3F800000) → 1.
  - fle(0x00000000, 0x80000000) → 1.
  - feq(0x7FC00000, 0x7FC00000) → 0.
  - All three: `done` in cycle 1, no stb ever asserted.
- **Timeout**
  - Stimulus: `TIMEOUT_CYCLES`=16; stub never asserts `out_stb`.
  - Required: `done` with `error`=1 and `result`=0 after 16 SEND+WAIT cycles; stbs low afterward.
- **Illegal op**
  - Stimulus: `op`=1111.
  - Required: `done` in cycle 1, `error`=1, no stb.
- **Reset and busy start**
  - Stimulus: `rst` pulsed in WAIT.
  - Required: all outputs return to reset values within the same cycle; a `start` issued while busy produces no extra `done`.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared opcode encoding, constants and sequencer state type for the FPU front end.
package fpu_pkg;

  localparam logic [3:0] FPU_FADD  = 4'b0000;
  localparam logic [3:0] FPU_FSUB  = 4'b0001;
  localparam logic [3:0] FPU_FMUL  = 4'b0010;
  localparam logic [3:0] FPU_FDIV  = 4'b0011;
  localparam logic [3:0] FPU_FSQRT = 4'b0100;
  localparam logic [3:0] FPU_FMIN  = 4'b0101;
  localparam logic [3:0] FPU_FMAX  = 4'b0110;
  localparam logic [3:0] FPU_FSGNJ = 4'b0111;
  localparam logic [3:0] FPU_FEQ   = 4'b1000;
  localparam logic [3:0] FPU_FLT   = 4'b1001;
  localparam logic [3:0] FPU_FLE   = 4'b1010;

  localparam logic [31:0] FPU_CANON_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_SEND,
    SEQ_WAIT,
    SEQ_ACK,
    SEQ_RESP
  } fpu_seq_state_t;

  function automatic logic is_compare_op(input logic [3:0] code);
    return (code == FPU_FEQ) || (code == FPU_FLT) || (code == FPU_FLE);
  endfunction

endpackage

// File: rtl/fpu_sequencer_if.sv
// Stb/ack bus between the sequencer (master) and the FPU controller (slave).
interface fpu_sequencer_if;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_in1;
  logic [31:0] fpu_in2;
  logic        fpu_in1_stb;
  logic        fpu_in2_stb;
  logic        fpu_in1_ack;
  logic        fpu_in2_ack;
  logic [31:0] fpu_out;
  logic        fpu_out_stb;
  logic        fpu_out_ack;

  modport master (
    output fpu_op, fpu_in1, fpu_in2, fpu_in1_stb, fpu_in2_stb, fpu_out_ack,
    input  fpu_in1_ack, fpu_in2_ack, fpu_out, fpu_out_stb
  );

  modport slave (
    input  fpu_op, fpu_in1, fpu_in2, fpu_in1_stb, fpu_in2_stb, fpu_out_ack,
    output fpu_in1_ack, fpu_in2_ack, fpu_out, fpu_out_stb
  );
endinterface

// File: rtl/fp_compare.sv
// Single-precision feq/flt/fle evaluated combinationally; op[1:0] 00=eq, 01=lt, 10=le.
module fp_compare (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  output logic        lt_eq_bit
);

  logic a_nan;
  logic b_nan;
  logic both_zero;
  logic eq;
  logic lt;

  // Signed zeros are equal; everything else orders by sign-magnitude.
  always_comb begin
    a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    eq        = both_zero || (a == b);
    if (both_zero)
      lt = 1'b0;
    else if (a[31] != b[31])
      lt = a[31];
    else if (a[31])
      lt = a[30:0] > b[30:0];
    else
      lt = a[30:0] < b[30:0];
    case (op)
      2'b00:   lt_eq_bit = eq;
      2'b01:   lt_eq_bit = lt;
      2'b10:   lt_eq_bit = lt | eq;
      default: lt_eq_bit = 1'b0;
    endcase
    if (a_nan || b_nan)
      lt_eq_bit = 1'b0;
  end

endmodule

// File: rtl/fpu_sequencer.sv
// Single-transaction sequencer between the execute stage and the FPU controller:
// stb/ack handshake, timeout, local compares, registered result with a done pulse.
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [31:0]   rs1,
  input  logic [31:0]   rs2,
  output logic          ready,
  output logic          done,
  output logic [31:0]   result,
  output logic          error,
  fpu_sequencer_if.master fpu
);

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  fpu_seq_state_t state;
  logic [3:0]  op_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic        in1_stb;
  logic        in2_stb;
  logic        out_ack;
  logic        ack1_flag;
  logic        ack2_flag;
  logic [15:0] timer;

  logic [15:0] timer_next;
  logic        timed_out;
  logic        ack1_set;
  logic        ack2_set;
  logic        cmp_bit;

  fp_compare u_compare (
    .a         (rs1),
    .b         (rs2),
    .op        (op[1:0]),
    .lt_eq_bit (cmp_bit)
  );

  assign fpu.fpu_op      = op_q;
  assign fpu.fpu_in1     = rs1_q;
  assign fpu.fpu_in2     = rs2_q;
  assign fpu.fpu_in1_stb = in1_stb;
  assign fpu.fpu_in2_stb = in2_stb;
  assign fpu.fpu_out_ack = out_ack;

  assign timer_next = timer + 16'd1;
  assign timed_out  = ((state == SEQ_SEND) || (state == SEQ_WAIT)) && (timer_next == TIMEOUT_LIMIT);
  assign ack1_set   = ack1_flag | fpu.fpu_in1_ack;
  assign ack2_set   = ack2_flag | fpu.fpu_in2_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEQ_IDLE;
      op_q      <= 4'd0;
      rs1_q     <= 32'd0;
      rs2_q     <= 32'd0;
      in1_stb   <= 1'b0;
      in2_stb   <= 1'b0;
      out_ack   <= 1'b0;
      ack1_flag <= 1'b0;
      ack2_flag <= 1'b0;
      timer     <= 16'd0;
      ready     <= 1'b1;
      done      <= 1'b0;
      result    <= FPU_CANON_ZERO;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort wins over any handshake progress in the same cycle.
      if (timed_out) begin
        in1_stb <= 1'b0;
        in2_stb <= 1'b0;
        result  <= FPU_CANON_ZERO;
        error   <= 1'b1;
        done    <= 1'b1;
        state   <= SEQ_RESP;
      end else begin
        case (state)
          SEQ_IDLE: begin
            if (start) begin
              op_q  <= op;
              rs1_q <= rs1;
              rs2_q <= rs2;
              ready <= 1'b0;
              if (is_compare_op(op)) begin
                result <= {31'd0, cmp_bit};
                error  <= 1'b0;
                done   <= 1'b1;
                state  <= SEQ_RESP;
              end else if (op > FPU_FLE) begin
                result <= FPU_CANON_ZERO;
                error  <= 1'b1;
                done   <= 1'b1;
                state  <= SEQ_RESP;
              end else begin
                timer     <= 16'd0;
                ack1_flag <= 1'b0;
                ack2_flag <= 1'b0;
                in1_stb   <= 1'b1;
                in2_stb   <= 1'b1;
                state     <= SEQ_SEND;
              end
            end
          end
          SEQ_SEND: begin
            timer     <= timer_next;
            ack1_flag <= ack1_set;
            ack2_flag <= ack2_set;
            if (ack1_set) in1_stb <= 1'b0;
            if (ack2_set) in2_stb <= 1'b0;
            if (ack1_set && ack2_set) state <= SEQ_WAIT;
          end
          SEQ_WAIT: begin
            timer <= timer_next;
            if (fpu.fpu_out_stb) begin
              result  <= fpu.fpu_out;
              error   <= 1'b0;
              out_ack <= 1'b1;
              state   <= SEQ_ACK;
            end
          end
          SEQ_ACK: begin
            out_ack <= 1'b0;
            done    <= 1'b1;
            state   <= SEQ_RESP;
          end
          SEQ_RESP: begin
            ready <= 1'b1;
            state <= SEQ_IDLE;
          end
          default: state <= SEQ_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed scoreboard bench for fpu_sequencer with a behavioural controller stub.
module tb_fpu_sequencer;
  import fpu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        start_to;
  logic [3:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        ready, done, error;
  logic [31:0] result;
  logic        ready_to, done_to, error_to;
  logic [31:0] result_to;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  int          ack1_lat = 0;
  int          ack2_lat = 0;
  int          out_lat  = 0;
  logic [31:0] stub_val = 32'd0;

  int       mon_drop1;
  int       mon_drop2;
  logic [3:0] mon_op_or;

  fpu_sequencer_if bus ();
  fpu_sequencer_if bus_to ();

  fpu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .ready(ready), .done(done), .result(result), .error(error), .fpu(bus)
  );

  fpu_sequencer #(.TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .rst(rst), .start(start_to), .op(op), .rs1(rs1), .rs2(rs2),
    .ready(ready_to), .done(done_to), .result(result_to), .error(error_to), .fpu(bus_to)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Controller stand-in: acks after a per-port latency, result after out_lat idle cycles.
  initial begin : stub
    int c1, c2, w;
    logic busy;
    c1 = 0; c2 = 0; w = 0; busy = 1'b0;
    bus.fpu_in1_ack = 1'b0;
    bus.fpu_in2_ack = 1'b0;
    bus.fpu_out_stb = 1'b0;
    bus.fpu_out     = 32'd0;
    bus_to.fpu_in1_ack = 1'b1;
    bus_to.fpu_in2_ack = 1'b1;
    bus_to.fpu_out_stb = 1'b0;
    bus_to.fpu_out     = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (bus.fpu_in1_stb) begin c1++; busy = 1'b1; end else c1 = 0;
      if (bus.fpu_in2_stb) c2++; else c2 = 0;
      if (bus.fpu_out_ack || rst) begin busy = 1'b0; w = 0; end
      else if (busy && !bus.fpu_in1_stb && !bus.fpu_in2_stb) w++;
      bus.fpu_in1_ack = (ack1_lat == 0) || (bus.fpu_in1_stb && c1 >= ack1_lat);
      bus.fpu_in2_ack = (ack2_lat == 0) || (bus.fpu_in2_stb && c2 >= ack2_lat);
      bus.fpu_out_stb = (out_lat == 0) || (busy && w >= out_lat);
      bus.fpu_out     = stub_val;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res, input logic exp_err,
                               input int exp_lat, input logic exp_stb);
    int cycles;
    int ack_cycles;
    logic stb_seen, seen1, seen2, ready_busy;
    logic [3:0] op_send;
    exp_t e;
    sb.push_back('{exp_res, exp_err});
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ack_cycles = 0; stb_seen = 1'b0; seen1 = 1'b0; seen2 = 1'b0;
    mon_drop1 = 0; mon_drop2 = 0; mon_op_or = 4'd0;
    ready_busy = ready; op_send = bus.fpu_op;
    for (cycles = 1; cycles <= 100; cycles++) begin
      if (bus.fpu_in1_stb || bus.fpu_in2_stb) stb_seen = 1'b1;
      if (bus.fpu_in1_stb) seen1 = 1'b1; else if (seen1 && mon_drop1 == 0) mon_drop1 = cycles;
      if (bus.fpu_in2_stb) seen2 = 1'b1; else if (seen2 && mon_drop2 == 0) mon_drop2 = cycles;
      if (bus.fpu_out_ack) ack_cycles++;
      mon_op_or = mon_op_or | bus.fpu_op;
      if (done) break;
      @(posedge clk); #1;
    end
    checkOutput({tag, " done seen"}, 32'(done), 32'd1);
    checkOutput({tag, " latency"}, cycles, exp_lat);
    e = sb.pop_front();
    checkOutput({tag, " result"}, result, e.res);
    checkOutput({tag, " error"}, 32'(error), 32'(e.err));
    checkOutput({tag, " stb seen"}, 32'(stb_seen), 32'(exp_stb));
    checkOutput({tag, " out_ack cycles"}, ack_cycles, exp_stb ? 1 : 0);
    checkOutput({tag, " ready busy"}, 32'(ready_busy), 32'd0);
    if (exp_stb) checkOutput({tag, " fpu_op held"}, 32'(op_send), 32'(o));
    @(posedge clk); #1;
    checkOutput({tag, " done pulse"}, 32'(done), 32'd0);
    checkOutput({tag, " ready after"}, 32'(ready), 32'd1);
  endtask

  initial begin : main
    int cycles;
    int done_cnt;
    exp_t e;
    rst = 1'b1; start = 1'b0; start_to = 1'b0;
    op = 4'd0; rs1 = 32'd0; rs2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset ready", 32'(ready), 32'd1);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset error", 32'(error), 32'd0);
    checkOutput("reset stbs", {30'd0, bus.fpu_in1_stb, bus.fpu_in2_stb}, 32'd0);
    checkOutput("reset out_ack", 32'(bus.fpu_out_ack), 32'd0);

    stub_val = 32'hBF80_0000;
    applyStimulus("fsgnj", FPU_FSGNJ, 32'h3F80_0000, 32'h8000_0000, 32'hBF80_0000, 1'b0, 4, 1'b1);
    applyStimulus("flt neg<pos", FPU_FLT, 32'hBF80_0000, 32'h3F80_0000, 32'd1, 1'b0, 1, 1'b0);
    applyStimulus("fle +0 -0", FPU_FLE, 32'h0000_0000, 32'h8000_0000, 32'd1, 1'b0, 1, 1'b0);
    applyStimulus("feq nan", FPU_FEQ, 32'h7FC0_0000, 32'h7FC0_0000, 32'd0, 1'b0, 1, 1'b0);
    applyStimulus("illegal op", 4'b1111, 32'h1234_5678, 32'h1, 32'd0, 1'b1, 1, 1'b0);
    applyStimulus("flt -2 -1", FPU_FLT, 32'hC000_0000, 32'hBF80_0000, 32'd1, 1'b0, 1, 1'b0);
    applyStimulus("flt -1 -2", FPU_FLT, 32'hBF80_0000, 32'hC000_0000, 32'd0, 1'b0, 1, 1'b0);

    ack1_lat = 2; ack2_lat = 5; out_lat = 10; stub_val = 32'h4040_0000;
    applyStimulus("fadd skew", FPU_FADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 17, 1'b1);
    checkOutput("fadd in1 stb drop", mon_drop1, 3);
    checkOutput("fadd in2 stb drop", mon_drop2, 6);
    checkOutput("fadd fpu_op zero", 32'(mon_op_or), 32'd0);

    // Give the timeout unit a nonzero result first so the abort must clear it.
    op = FPU_FLT; rs1 = 32'hBF80_0000; rs2 = 32'h3F80_0000; start_to = 1'b1;
    @(posedge clk); #1;
    start_to = 1'b0;
    checkOutput("to prep result", result_to, 32'd1);
    @(posedge clk); #1;
    op = FPU_FADD; rs1 = 32'h3F80_0000; rs2 = 32'h3F80_0000; start_to = 1'b1;
    @(posedge clk); #1;
    start_to = 1'b0;
    for (cycles = 1; cycles <= 60; cycles++) begin
      if (done_to) break;
      @(posedge clk); #1;
    end
    checkOutput("timeout done", 32'(done_to), 32'd1);
    checkOutput("timeout latency", cycles, 17);
    checkOutput("timeout error", 32'(error_to), 32'd1);
    checkOutput("timeout result", result_to, 32'd0);
    @(posedge clk); #1;
    checkOutput("timeout stbs low", {30'd0, bus_to.fpu_in1_stb, bus_to.fpu_in2_stb}, 32'd0);
    checkOutput("timeout ready", 32'(ready_to), 32'd1);

    ack1_lat = 1; ack2_lat = 1; out_lat = 30; stub_val = 32'h1111_2222;
    op = FPU_FMUL; rs1 = 32'h4000_0000; rs2 = 32'h4040_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("pre-reset busy", 32'(ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst ready", 32'(ready), 32'd1);
    checkOutput("midrst result", result, 32'd0);
    checkOutput("midrst fpu_op", 32'(bus.fpu_op), 32'd0);
    checkOutput("midrst fpu_in1", bus.fpu_in1, 32'd0);
    checkOutput("midrst outs", {28'd0, done, error, bus.fpu_in1_stb, bus.fpu_out_ack}, 32'd0);
    #4 rst = 1'b0;

    ack1_lat = 0; ack2_lat = 0; out_lat = 0; stub_val = 32'hBF80_0000;
    @(posedge clk); #1;
    sb.push_back('{32'hBF80_0000, 1'b0});
    op = FPU_FSGNJ; rs1 = 32'h3F80_0000; rs2 = 32'h8000_0000; start = 1'b1;
    @(posedge clk); #1;
    op = FPU_FEQ; rs1 = 32'h1; rs2 = 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        done_cnt++;
        e = sb.pop_front();
        checkOutput("busy start result", result, e.res);
      end
      @(posedge clk); #1;
    end
    checkOutput("busy start done count", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
